// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU/UART command sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {IDLE, EXEC, SEND, ACK, DRAIN} seq_state_e;

  // Opcode encoding shared with the combinational ALU.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  // Bytes per command: result bytes rounded up, plus the optional header.
  function automatic int calc_nb(input int res_w, input int header_en);
    return (res_w + 7) / 8 + header_en;
  endfunction

endpackage

// File: rtl/alu_seq_byte_sel.sv
// Picks the byte to transmit: opcode header at index 0 when enabled,
// otherwise the result byte, with the top byte zero-padded.
module alu_seq_byte_sel #(
  parameter int RES_W     = 16,
  parameter int OPCODE_W  = 3,
  parameter int HEADER_EN = 0,
  parameter int IDX_W     = 2
) (
  input  logic [RES_W-1:0]    res,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [IDX_W-1:0]    idx,
  output logic [7:0]          byte_o
);

  localparam int RBYTES = (RES_W + 7) / 8;

  logic [RBYTES*8-1:0] res_pad;

  // Zero-extend the result to a whole number of bytes.
  always_comb begin
    res_pad = '0;
    res_pad[RES_W-1:0] = res;
  end

  // Index-to-byte mux; result byte j sits at idx j+HEADER_EN.
  always_comb begin
    byte_o = '0;
    if (HEADER_EN != 0 && idx == '0) begin
      byte_o = 8'(opcode);
    end else begin
      for (int j = 0; j < RBYTES; j++) begin
        if (idx == IDX_W'(j + HEADER_EN)) byte_o = res_pad[j*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Command sequencer: latches operands for the ALU, captures the result and
// serialises it LSB byte first over the UART with busy handshake and timeout.
module alu_uart_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OPCODE_W    = 3,
  parameter int RES_W       = 2 * DATA_W,
  parameter int HEADER_EN   = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [OPCODE_W-1:0] cmd_opcode,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OPCODE_W-1:0] alu_opcode,
  input  logic [RES_W-1:0]    alu_result,
  output logic                uart_start,
  output logic [7:0]          uart_data,
  input  logic                uart_busy,
  output logic                done,
  output logic                err_timeout
);

  localparam int NB    = calc_nb(RES_W, HEADER_EN);
  localparam int IDX_W = $clog2(NB + 1);

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OPCODE_W-1:0] alu_op_q, alu_op_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [7:0]          uart_data_q, uart_data_d;
  logic                uart_start_q, uart_start_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  // The first byte leaves while res_q is still being loaded, so it is taken
  // straight from the ALU; later bytes come from the captured result.
  logic [RES_W-1:0] sel_res;
  logic [IDX_W-1:0] sel_idx;
  logic [7:0]       sel_byte;

  assign sel_res = (state_q == EXEC) ? alu_result : res_q;
  assign sel_idx = (state_q == EXEC) ? '0 : idx_q + 1'b1;

  alu_seq_byte_sel #(
    .RES_W(RES_W), .OPCODE_W(OPCODE_W), .HEADER_EN(HEADER_EN), .IDX_W(IDX_W)
  ) u_byte_sel (
    .res(sel_res), .opcode(alu_op_q), .idx(sel_idx), .byte_o(sel_byte)
  );

  // Next-state and registered-output logic. uart_start is raised on entry to
  // SEND so the pulse occupies exactly the SEND cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    res_d        = res_q;
    uart_data_d  = uart_data_q;
    uart_start_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        alu_a_d  = cmd_a;
        alu_b_d  = cmd_b;
        alu_op_d = cmd_opcode;
        idx_d    = '0;
        err_d    = 1'b0;
        state_d  = EXEC;
      end
      EXEC: begin
        res_d        = alu_result;
        uart_data_d  = sel_byte;
        uart_start_d = 1'b1;
        state_d      = SEND;
      end
      SEND: begin
        cnt_d   = '0;
        state_d = ACK;
      end
      // The SEND cycle counts as the first waited cycle, so the error fires
      // ACK_TIMEOUT cycles after the start pulse.
      ACK: begin
        if (uart_busy) begin
          state_d = DRAIN;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 2)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: if (!uart_busy) begin
        if (idx_q == IDX_W'(NB - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d        = idx_q + 1'b1;
          uart_data_d  = sel_byte;
          uart_start_d = 1'b1;
          state_d      = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      res_q        <= '0;
      uart_data_q  <= '0;
      uart_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      res_q        <= res_d;
      uart_data_q  <= uart_data_d;
      uart_start_q <= uart_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_op_q;
  assign uart_start  = uart_start_q;
  assign uart_data   = uart_data_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench: three sequencer configurations driven by a table of
// commands, plus hand sequences for back-to-back, timeout and reset cases.
module tb_alu_uart_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vld[3];
  logic [31:0] ca[3], cb[3];
  logic [2:0]  cop[3];
  logic        rdy[3], st[3], dn[3], er[3];
  logic [7:0]  ud[3];
  logic        busy[3] = '{1'b0, 1'b0, 1'b0};
  logic        uen[3];

  logic [7:0]  a0, b0, a1, b1;
  logic [11:0] a2, b2;
  logic [2:0]  o0, o1, o2;
  logic [15:0] r0, r1;
  logic [23:0] r2;

  function automatic logic [63:0] alu_f(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'd0: return 64'(a) + 64'(b);
      3'd1: return 64'(a) - 64'(b);
      3'd2: return 64'(a) * 64'(b);
      3'd3: return 64'(a & b);
      3'd4: return 64'(a | b);
      3'd5: return 64'(a ^ b);
      default: return 64'd0;
    endcase
  endfunction

  assign r0 = 16'(alu_f(32'(a0), 32'(b0), o0));
  assign r1 = 16'(alu_f(32'(a1), 32'(b1), o1));
  assign r2 = 24'(alu_f(32'(a2), 32'(b2), o2));

  alu_uart_sequencer #(.DATA_W(8), .HEADER_EN(0), .ACK_TIMEOUT(16)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_a(ca[0][7:0]), .cmd_b(cb[0][7:0]), .cmd_opcode(cop[0]),
    .alu_a(a0), .alu_b(b0), .alu_opcode(o0), .alu_result(r0),
    .uart_start(st[0]), .uart_data(ud[0]), .uart_busy(busy[0]),
    .done(dn[0]), .err_timeout(er[0]));

  alu_uart_sequencer #(.DATA_W(8), .HEADER_EN(1), .ACK_TIMEOUT(16)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_a(ca[1][7:0]), .cmd_b(cb[1][7:0]), .cmd_opcode(cop[1]),
    .alu_a(a1), .alu_b(b1), .alu_opcode(o1), .alu_result(r1),
    .uart_start(st[1]), .uart_data(ud[1]), .uart_busy(busy[1]),
    .done(dn[1]), .err_timeout(er[1]));

  alu_uart_sequencer #(.DATA_W(12), .HEADER_EN(0), .ACK_TIMEOUT(16)) u2 (
    .clk(clk), .rst(rst), .cmd_valid(vld[2]), .cmd_ready(rdy[2]),
    .cmd_a(ca[2][11:0]), .cmd_b(cb[2][11:0]), .cmd_opcode(cop[2]),
    .alu_a(a2), .alu_b(b2), .alu_opcode(o2), .alu_result(r2),
    .uart_start(st[2]), .uart_data(ud[2]), .uart_busy(busy[2]),
    .done(dn[2]), .err_timeout(er[2]));

  // UART model: records each started byte, raises busy 2 cycles after the
  // start for 10 cycles (unless disabled), and watches uart_data while busy.
  int         sent_n[3]   = '{0, 0, 0};
  logic [7:0] sent[3][64];
  int         dly[3]      = '{0, 0, 0};
  int         bcnt[3]     = '{0, 0, 0};
  logic [7:0] held[3];
  int         stab_err[3] = '{0, 0, 0};
  int         done_n[3]   = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (st[i]) begin
        if (sent_n[i] < 64) sent[i][sent_n[i]] <= ud[i];
        sent_n[i] <= sent_n[i] + 1;
        held[i]   <= ud[i];
        if (uen[i]) dly[i] <= 2;
      end else if (dly[i] != 0) begin
        dly[i] <= dly[i] - 1;
        if (dly[i] == 1) begin
          busy[i] <= 1'b1;
          bcnt[i] <= 10;
        end
      end else if (bcnt[i] != 0) begin
        if (ud[i] != held[i]) stab_err[i] <= stab_err[i] + 1;
        bcnt[i] <= bcnt[i] - 1;
        if (bcnt[i] == 1) busy[i] <= 1'b0;
      end
      if (dn[i]) done_n[i] <= done_n[i] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present a command and return at the negedge right after acceptance.
  task automatic send_cmd(input int i, input logic [31:0] a, b, input logic [2:0] op);
    int n = 0;
    ca[i] = a; cb[i] = b; cop[i] = op; vld[i] = 1'b1;
    while (!rdy[i] && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  // Wait for the done pulse; returns at the negedge of the done cycle.
  task automatic wait_done(input int i);
    int n = 0;
    do begin @(negedge clk); n++; end while (!dn[i] && n < 400);
    chk("done_seen", 64'(dn[i]), 64'd1);
  endtask

  task automatic chk_bytes(input int i, input int base, input int nb, input logic [3:0][7:0] exp);
    chk("byte_count", 64'(sent_n[i] - base), 64'(nb));
    for (int k = 0; k < nb; k++) chk($sformatf("byte%0d_inst%0d", k, i), 64'(sent[i][base+k]), 64'(exp[k]));
  endtask

  typedef struct {
    int              inst;
    logic [31:0]     a, b;
    logic [2:0]      op;
    int              nb;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    int base, dbase, n;
    vt[0] = '{0, 32'd5,     32'd10,    3'd0, 2, {8'h00, 8'h00, 8'h00, 8'h0F}};
    vt[1] = '{0, 32'hFF,    32'hFF,    3'd2, 2, {8'h00, 8'h00, 8'hFE, 8'h01}};
    vt[2] = '{0, 32'd3,     32'd5,     3'd1, 2, {8'h00, 8'h00, 8'hFF, 8'hFE}};
    vt[3] = '{1, 32'hFF,    32'hFF,    3'd2, 3, {8'h00, 8'hFE, 8'h01, 8'h02}};
    vt[4] = '{1, 32'hA5,    32'h0F,    3'd5, 3, {8'h00, 8'h00, 8'hAA, 8'h05}};
    vt[5] = '{2, 32'hFFF,   32'hFFF,   3'd2, 3, {8'h00, 8'hFF, 8'hE0, 8'h01}};
    vt[6] = '{2, 32'h800,   32'h900,   3'd0, 3, {8'h00, 8'h00, 8'h11, 8'h00}};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; ca[i] = '0; cb[i] = '0; cop[i] = '0; uen[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(rdy[0]), 64'd1);
    chk("rst_start", 64'(st[0]), 64'd0);
    chk("rst_data",  64'(ud[0]), 64'd0);
    chk("rst_done",  64'(dn[1]), 64'd0);
    chk("rst_err",   64'(er[2]), 64'd0);
    chk("rst_alu_a", 64'(a0), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven commands across the three configurations.
    for (int v = 0; v < 7; v++) begin
      base  = sent_n[vt[v].inst];
      dbase = done_n[vt[v].inst];
      send_cmd(vt[v].inst, vt[v].a, vt[v].b, vt[v].op);
      wait_done(vt[v].inst);
      chk("ready_in_done", 64'(rdy[vt[v].inst]), 64'd1);
      @(negedge clk);
      chk_bytes(vt[v].inst, base, vt[v].nb, vt[v].exp);
      chk("done_pulses", 64'(done_n[vt[v].inst] - dbase), 64'd1);
      chk("no_timeout", 64'(er[vt[v].inst]), 64'd0);
    end
    chk("stable_u0", 64'(stab_err[0]), 64'd0);
    chk("stable_u1", 64'(stab_err[1]), 64'd0);

    // First-byte latency: EXEC cycle after acceptance, then start.
    base = sent_n[0];
    send_cmd(0, 32'h21, 32'h11, 3'd4);
    chk("alu_a_latched", 64'(a0), 64'h21);
    chk("exec_no_start", 64'(st[0]), 64'd0);
    @(negedge clk);
    chk("send_start", 64'(st[0]), 64'd1);
    chk("send_data",  64'(ud[0]), 64'h31);
    wait_done(0);
    @(negedge clk);

    // Back-to-back with cmd_valid held: second taken in the done cycle.
    base = sent_n[0]; dbase = done_n[0];
    ca[0] = 32'd1; cb[0] = 32'd2; cop[0] = 3'd0; vld[0] = 1'b1;
    @(negedge clk);
    ca[0] = 32'h10; cb[0] = 32'h10; cop[0] = 3'd2;
    wait_done(0);
    chk("b2b_ready_done", 64'(rdy[0]), 64'd1);
    @(negedge clk);
    vld[0] = 1'b0;
    chk("b2b_accepted", 64'(rdy[0]), 64'd0);
    wait_done(0);
    @(negedge clk);
    chk_bytes(0, base, 4, {8'h01, 8'h00, 8'h00, 8'h03});
    chk("b2b_done_pulses", 64'(done_n[0] - dbase), 64'd2);

    // ACK timeout: busy never rises.
    uen[0] = 1'b0;
    base = sent_n[0];
    send_cmd(0, 32'd1, 32'd1, 3'd0);
    @(negedge clk);
    chk("to_start", 64'(st[0]), 64'd1);
    n = 0;
    while (!er[0] && n < 100) begin @(negedge clk); n++; end
    chk("to_latency", 64'(n), 64'd16);
    chk("to_done", 64'(dn[0]), 64'd1);
    chk("to_idle", 64'(rdy[0]), 64'd1);
    @(negedge clk);
    chk("to_done_once", 64'(dn[0]), 64'd0);
    chk("to_sticky", 64'(er[0]), 64'd1);
    chk("to_one_byte", 64'(sent_n[0] - base), 64'd1);
    uen[0] = 1'b1;
    base = sent_n[0];
    send_cmd(0, 32'd2, 32'd2, 3'd0);
    chk("to_cleared", 64'(er[0]), 64'd0);
    wait_done(0);
    @(negedge clk);
    chk_bytes(0, base, 2, {8'h00, 8'h00, 8'h00, 8'h04});

    // Reset during DRAIN of byte 1.
    base = sent_n[0];
    send_cmd(0, 32'h12, 32'h34, 3'd0);
    n = 0;
    while (sent_n[0] != base + 2 && n < 200) begin @(negedge clk); n++; end
    chk("rst_reached_byte1", 64'(sent_n[0] - base), 64'd2);
    repeat (5) @(negedge clk);
    chk("in_drain_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(rdy[0]), 64'd1);
    chk("mid_rst_data",  64'(ud[0]), 64'd0);
    chk("mid_rst_start", 64'(st[0]), 64'd0);
    chk("mid_rst_done",  64'(dn[0]), 64'd0);
    chk("mid_rst_alu_a", 64'(a0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy[0] && n < 50) begin @(negedge clk); n++; end
    base = sent_n[0];
    send_cmd(0, 32'h20, 32'h03, 3'd0);
    wait_done(0);
    @(negedge clk);
    chk_bytes(0, base, 2, {8'h00, 8'h00, 8'h00, 8'h23});
    chk("post_rst_err", 64'(er[0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
